rhythm_judge: RTL and testbench

Multi-lane successor to the single-lane rhythm datapath. Holds one note shift register per lane, advances all lanes on a beat strobe, and judges edge-detected player presses as perfect, good or miss per lane. Accumulates score, combo and maximum combo. Sits between the beat clock divider and the HEX/VGA/LED renderers, which read `lane_view`, `accuracy`, `score` and `combo`.

---
 rtl/rhythm_judge.sv | 186 ++++++++++++++++++
 tb/tb_rhythm_judge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhythm_judge.sv
// rhythm_judge: multi-lane note shifter and press judge with score/combo.
// Ports: clk, rst (sync, active-low), tick, load, map_in, btn_n -> lane_view,
//   accuracy, score, combo, max_combo, playing, done.
// Option: define RHYTHM_JUDGE_MAX_COMBO_EN to build the max_combo register;
//   otherwise max_combo is tied to 0.
module rhythm_judge #(
   parameter int LANES   = 4,
   parameter int MAP_LEN = 192,
   parameter int SCORE_W = 16,
   parameter int COMBO_W = 8,
   parameter int VIEW    = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       load,
   input  logic [LANES*MAP_LEN-1:0]   map_in,
   input  logic [LANES-1:0]           btn_n,
   output logic [LANES*VIEW-1:0]      lane_view,
   output logic [2*LANES-1:0]         accuracy,
   output logic [SCORE_W-1:0]         score,
   output logic [COMBO_W-1:0]         combo,
   output logic [COMBO_W-1:0]         max_combo,
   output logic                       playing,
   output logic                       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [SCORE_W-1:0] SMAX = '1;
   localparam logic [COMBO_W-1:0] CMAX = '1;

   state_t state, state_n;

   logic [LANES*MAP_LEN-1:0] lanes, lanes_n;
   logic [2*LANES-1:0]       acc_n;
   logic [LANES-1:0]         sync1, sync2, sync3, press;
   logic [MAP_LEN-1:0]       cur;
   logic [4:0]               pts;
   logic [3:0]               hits;
   logic                     miss;
   logic [SCORE_W+5:0]       score_sum;
   logic [COMBO_W+4:0]       combo_sum;
   logic [SCORE_W-1:0]       score_n;
   logic [COMBO_W-1:0]       combo_n;

   // sync3 holds the previous synchronized level; a 1->0 step is a press
   assign press = sync3 & ~sync2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= '1;
         sync2 <= '1;
         sync3 <= '1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (load) state_n = PLAY;
         PLAY: begin
            if (load)
               state_n = PLAY;
            else if (lanes == '0)
               state_n = DONE;
         end
         DONE: if (load) state_n = PLAY;
         default: state_n = IDLE;
      endcase
   end

   // Hits clear their slot first; the miss test and the shift then see
   // the cleared lane.
   always_comb begin
      lanes_n = lanes;
      acc_n   = accuracy;
      pts     = '0;
      hits    = '0;
      miss    = 1'b0;
      cur     = '0;
      for (int k = 0; k < LANES; k++) begin
         cur = lanes[k*MAP_LEN +: MAP_LEN];
         if (press[k]) begin
            if (cur[1]) begin
               cur[1] = 1'b0;
               acc_n[2*k +: 2] = 2'b01;
               pts  = pts + 5'd2;
               hits = hits + 4'd1;
            end else if (cur[0]) begin
               cur[0] = 1'b0;
               acc_n[2*k +: 2] = 2'b10;
               pts  = pts + 5'd1;
               hits = hits + 4'd1;
            end else if (cur[2]) begin
               cur[2] = 1'b0;
               acc_n[2*k +: 2] = 2'b10;
               pts  = pts + 5'd1;
               hits = hits + 4'd1;
            end else begin
               acc_n[2*k +: 2] = 2'b00;
            end
         end
         if (tick) begin
            if (cur[0]) begin
               acc_n[2*k +: 2] = 2'b11;
               miss = 1'b1;
            end
            cur = cur >> 1;
         end
         lanes_n[k*MAP_LEN +: MAP_LEN] = cur;
      end
   end

   assign score_sum = {6'b0, score} + {{(SCORE_W+1){1'b0}}, pts};
   assign combo_sum = {5'b0, combo} + {{(COMBO_W+1){1'b0}}, hits};

   always_comb begin
      score_n = score_sum[SCORE_W-1:0];
      if (score_sum > {6'b0, SMAX})
         score_n = SMAX;
      combo_n = combo_sum[COMBO_W-1:0];
      if (combo_sum > {5'b0, CMAX})
         combo_n = CMAX;
      if (miss)
         combo_n = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         lanes    <= '0;
         accuracy <= '0;
         score    <= '0;
         combo    <= '0;
         playing  <= 1'b0;
         done     <= 1'b0;
      end else begin
         state   <= state_n;
         playing <= (state_n == PLAY);
         done    <= (state_n == DONE);
         if (load) begin
            lanes    <= map_in;
            accuracy <= '0;
            score    <= '0;
            combo    <= '0;
         end else if (state == PLAY) begin
            lanes    <= lanes_n;
            accuracy <= acc_n;
            score    <= score_n;
            combo    <= combo_n;
         end
      end
   end

`ifdef RHYTHM_JUDGE_MAX_COMBO_EN
   logic [COMBO_W-1:0] maxc;

   always_ff @(posedge clk) begin
      if (!rst)
         maxc <= '0;
      else if (load)
         maxc <= '0;
      else if (state == PLAY && combo_n > maxc)
         maxc <= combo_n;
   end

   assign max_combo = maxc;
`else
   assign max_combo = '0;
`endif

   // Display exports slots VIEW..1 of each lane straight from the registers
   for (genvar k = 0; k < LANES; k++) begin : g_view
      assign lane_view[k*VIEW +: VIEW] = lanes[k*MAP_LEN+1 +: VIEW];
   end

endmodule

// File: tb/tb_rhythm_judge.sv
// tb_rhythm_judge: scoreboard bench for rhythm_judge (LANES=2, MAP_LEN=16,
// SCORE_W=4, VIEW=4); expectations follow RHYTHM_JUDGE_MAX_COMBO_EN if set.
module tb_rhythm_judge;

   localparam int L  = 2;
   localparam int ML = 16;
   localparam int SW = 4;
   localparam int CW = 8;
   localparam int V  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            tick = 1'b0;
   logic            load = 1'b0;
   logic [L*ML-1:0] map_in = '0;
   logic [L-1:0]    btn_n = '1;
   logic [L*V-1:0]  lane_view;
   logic [2*L-1:0]  accuracy;
   logic [SW-1:0]   score;
   logic [CW-1:0]   combo;
   logic [CW-1:0]   max_combo;
   logic            playing;
   logic            done;

   rhythm_judge #(
      .LANES(L), .MAP_LEN(ML), .SCORE_W(SW), .COMBO_W(CW), .VIEW(V)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .load(load), .map_in(map_in),
      .btn_n(btn_n), .lane_view(lane_view), .accuracy(accuracy),
      .score(score), .combo(combo), .max_combo(max_combo),
      .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] acc;
      logic [3:0] score;
      logic [7:0] combo;
      logic [7:0] maxc;
      logic [7:0] view;
      logic       play;
      logic       dn;
   } exp_t;

   exp_t  expq[$];
   string tagq[$];
   int    errors = 0;
   int    checks = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mc(input logic [7:0] v);
`ifdef RHYTHM_JUDGE_MAX_COMBO_EN
      return v;
`else
      return 8'd0;
`endif
   endfunction

   task automatic push_exp(input string tag, input logic [3:0] a,
                           input logic [3:0] s, input logic [7:0] c,
                           input logic [7:0] m, input logic [7:0] v,
                           input logic p, input logic d);
      exp_t e;
      e = '{acc: a, score: s, combo: c, maxc: m, view: v, play: p, dn: d};
      expq.push_back(e);
      tagq.push_back(tag);
   endtask

   task automatic pop_check();
      exp_t  e;
      string t;
      check("sb_depth", expq.size(), 1);
      e = expq.pop_front();
      t = tagq.pop_front();
      check({t, ".acc"}, accuracy, e.acc);
      check({t, ".score"}, score, e.score);
      check({t, ".combo"}, combo, e.combo);
      check({t, ".maxc"}, max_combo, e.maxc);
      check({t, ".view"}, lane_view, e.view);
      check({t, ".play"}, playing, e.play);
      check({t, ".done"}, done, e.dn);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] m0, input logic [15:0] m1);
      map_in = {m1, m0};
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic press(input int k);
      btn_n[k] = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic release_btn(input int k);
      btn_n[k] = 1'b1;
      step();
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v0, v1;
      step();
      step();
      push_exp("reset", 4'h0, 4'd0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
      pop_check();
      rst = 1'b1;
      step();

      push_exp("idle_press", 4'h0, 4'd0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
      press(0);
      pop_check();
      release_btn(0);

      // perfect hit before any tick, then drain to DONE
      push_exp("t1_load", 4'h0, 4'd0, 8'd0, 8'd0, 8'h01, 1'b1, 1'b0);
      do_load(16'h0002, 16'h0000);
      pop_check();
      push_exp("t1_hit", 4'b0001, 4'd2, 8'd1, mc(1), 8'h00, 1'b1, 1'b0);
      press(0);
      pop_check();
      push_exp("t1_done", 4'b0001, 4'd2, 8'd1, mc(1), 8'h00, 1'b0, 1'b1);
      release_btn(0);
      pop_check();

      // three hits on lane1, miss on lane0, one more hit
      push_exp("t2_load", 4'h0, 4'd0, 8'd0, 8'd0, 8'hB0, 1'b1, 1'b0);
      do_load(16'h0001, 16'h0017);
      pop_check();
      push_exp("t2_h1", 4'b0100, 4'd2, 8'd1, mc(1), 8'hA0, 1'b1, 1'b0);
      press(1);
      pop_check();
      release_btn(1);
      push_exp("t2_h2", 4'b1000, 4'd3, 8'd2, mc(2), 8'hA0, 1'b1, 1'b0);
      press(1);
      pop_check();
      release_btn(1);
      push_exp("t2_h3", 4'b1000, 4'd4, 8'd3, mc(3), 8'h80, 1'b1, 1'b0);
      press(1);
      pop_check();
      release_btn(1);
      push_exp("t2_miss", 4'b1011, 4'd4, 8'd0, mc(3), 8'h40, 1'b1, 1'b0);
      pulse_tick();
      pop_check();
      push_exp("t2_shift", 4'b1011, 4'd4, 8'd0, mc(3), 8'h10, 1'b1, 1'b0);
      pulse_tick();
      pulse_tick();
      pop_check();
      push_exp("t2_h4", 4'b0111, 4'd6, 8'd1, mc(3), 8'h00, 1'b1, 1'b0);
      press(1);
      pop_check();
      release_btn(1);

      // both lanes hit in the same cycle as a tick
      push_exp("t3_load", 4'h0, 4'd0, 8'd0, 8'd0, 8'h01, 1'b1, 1'b0);
      do_load(16'h0002, 16'h0001);
      pop_check();
      push_exp("t3_both", 4'b1001, 4'd3, 8'd2, mc(2), 8'h00, 1'b1, 1'b0);
      btn_n = 2'b00;
      step();
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      pop_check();
      release_btn(0);
      release_btn(1);

      // held button gives one judgement; later notes fall off as misses
      do_load(16'h000E, 16'h0000);
      push_exp("t4_hit", 4'b0001, 4'd2, 8'd1, mc(1), 8'h06, 1'b1, 1'b0);
      press(0);
      pop_check();
      push_exp("t4_hold", 4'b0011, 4'd2, 8'd0, mc(1), 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         pulse_tick();
         step();
      end
      pop_check();
      release_btn(0);

      // reset mid-song overrides load and tick
      push_exp("t6_load", 4'h0, 4'd0, 8'd0, 8'd0, 8'h08, 1'b1, 1'b0);
      do_load(16'h00F0, 16'h0000);
      pop_check();
      push_exp("t6_rst", 4'h0, 4'd0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      load = 1'b1;
      tick = 1'b1;
      step();
      rst = 1'b1;
      load = 1'b0;
      tick = 1'b0;
      pop_check();

      // eight perfects with SCORE_W=4: score saturates at 15
      do_load(16'hAAAA, 16'h8000);
      for (int k = 1; k <= 8; k++) begin
         v0 = 16'hAAAA >> (2 * (k - 1));
         v0[1] = 1'b0;
         v1 = 16'h8000 >> (2 * (k - 1));
         push_exp($sformatf("t5_p%0d", k), 4'b0001,
                  (2 * k > 15) ? 4'd15 : 4'(2 * k), 8'(k), mc(8'(k)),
                  {v1[4:1], v0[4:1]}, 1'b1, 1'b0);
         press(0);
         pop_check();
         release_btn(0);
         if (k < 8) begin
            pulse_tick();
            pulse_tick();
         end
      end

      // restart mid-song, then drain with a final miss
      push_exp("t5_reload", 4'h0, 4'd0, 8'd0, 8'd0, 8'h01, 1'b1, 1'b0);
      do_load(16'h0002, 16'h0000);
      pop_check();
      push_exp("t5_tick", 4'h0, 4'd0, 8'd0, 8'd0, 8'h00, 1'b1, 1'b0);
      pulse_tick();
      pop_check();
      push_exp("t5_miss", 4'b0011, 4'd0, 8'd0, 8'd0, 8'h00, 1'b1, 1'b0);
      pulse_tick();
      pop_check();
      push_exp("t5_done", 4'b0011, 4'd0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b1);
      step();
      pop_check();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
